// File: rtl/pawn_sched.sv
// pawn_sched: walks every selected pawn of one colour through the pawn
// move-generation block and returns the total number of boards produced.
// CPU side is an Avalon-MM slave, pawn-block side an Avalon-MM master.
// Optional cycle counter at CPU address 6, enabled by PAWN_SCHED_PERF_EN.
module pawn_sched #(
    parameter int MAX_MOVES = 12,
    parameter int NUM_PAWNS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        gen_waitrequest,
    output logic [3:0]  gen_address,
    output logic        gen_read,
    input  logic [31:0] gen_readdata,
    output logic        gen_write,
    output logic [31:0] gen_writedata
);

    localparam int IDX_W = $clog2(NUM_PAWNS + 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SCAN    = 4'd1,
        W_BOARD = 4'd2,
        W_PIECE = 4'd3,
        W_DEST  = 4'd4,
        W_START = 4'd5,
        R_COUNT = 4'd6,
        ACCUM   = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t                 state_r, state_s;
    logic [31:0]            board_r, base_r;
    logic                   colour_r;
    logic [NUM_PAWNS-1:0]   mask_r;
    logic [IDX_W-1:0]       idx_r, idx_s, pawn_r, pawn_s, sel_s;
    logic [31:0]            dest_r, dest_s;
    logic [7:0]             count_r, count_s;
    logic [6:0]             total_r, total_s;
    logic                   clamp_r, clamp_s;
    logic                   gen_read_r, gen_write_r, rd_s, wr_s;
    logic [3:0]             gen_address_r, addr_s;
    logic [31:0]            gen_writedata_r, wdata_s;
    logic                   found_s, start_s, over_s;
    logic [7:0]             clamped_s;
    logic [31:0]            piece_abs_s, piece_id_s, perf_rd_s;
    logic                   unused_readdata_hi_s;

    assign gen_read      = gen_read_r;
    assign gen_write     = gen_write_r;
    assign gen_address   = gen_address_r;
    assign gen_writedata = gen_writedata_r;

    // The pawn block only reports counts in the low byte.
    assign unused_readdata_hi_s = ^gen_readdata[31:8];

    assign start_s = (state_r == IDLE) && slave_write && (slave_address == 4'd0);

    // Lowest selected pawn at or above the current scan index.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {IDX_W{1'b0}};
        for (int i = NUM_PAWNS - 1; i >= 0; i--) begin
            if (mask_r[i] && (IDX_W'(i) >= idx_r)) begin
                found_s = 1'b1;
                sel_s   = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Signed piece ID and clamped board count for the current pawn.
    always_comb begin
        piece_abs_s = 32'(pawn_r) + 32'd1;
        if (colour_r) begin
            piece_id_s = ~piece_abs_s + 32'd1;
        end else begin
            piece_id_s = piece_abs_s;
        end
        over_s = gen_readdata[7:0] > 8'(MAX_MOVES);
        if (over_s) begin
            clamped_s = 8'(MAX_MOVES);
        end else begin
            clamped_s = gen_readdata[7:0];
        end
    end

    // Sequencer next state plus next values of the master-side outputs.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        pawn_s  = pawn_r;
        dest_s  = dest_r;
        total_s = total_r;
        count_s = count_r;
        clamp_s = clamp_r;
        rd_s    = gen_read_r;
        wr_s    = gen_write_r;
        addr_s  = gen_address_r;
        wdata_s = gen_writedata_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = SCAN;
                    idx_s   = {IDX_W{1'b0}};
                    total_s = 7'd0;
                    count_s = 8'd0;
                    clamp_s = 1'b0;
                    dest_s  = base_r;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (found_s) begin
                    state_s = W_BOARD;
                    pawn_s  = sel_s;
                    wr_s    = 1'b1;
                    addr_s  = 4'd1;
                    wdata_s = board_r;
                end else begin
                    state_s = DONE;
                end
            end
            W_BOARD: begin
                if (!gen_waitrequest) begin
                    state_s = W_PIECE;
                    addr_s  = 4'd2;
                    wdata_s = piece_id_s;
                end else begin
                    state_s = W_BOARD;
                end
            end
            W_PIECE: begin
                if (!gen_waitrequest) begin
                    state_s = W_DEST;
                    addr_s  = 4'd3;
                    wdata_s = dest_r;
                end else begin
                    state_s = W_PIECE;
                end
            end
            W_DEST: begin
                if (!gen_waitrequest) begin
                    state_s = W_START;
                    addr_s  = 4'd0;
                    wdata_s = 32'd0;
                end else begin
                    state_s = W_DEST;
                end
            end
            W_START: begin
                if (!gen_waitrequest) begin
                    state_s = R_COUNT;
                    wr_s    = 1'b0;
                    rd_s    = 1'b1;
                    addr_s  = 4'd0;
                    wdata_s = 32'd0;
                end else begin
                    state_s = W_START;
                end
            end
            R_COUNT: begin
                if (!gen_waitrequest) begin
                    state_s = ACCUM;
                    rd_s    = 1'b0;
                    count_s = clamped_s;
                    clamp_s = clamp_r | over_s;
                end else begin
                    state_s = R_COUNT;
                end
            end
            ACCUM: begin
                state_s = SCAN;
                total_s = total_r + count_r[6:0];
                dest_s  = dest_r + {18'd0, count_r, 6'd0};
                idx_s   = pawn_r + IDX_W'(1);
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                rd_s    = 1'b0;
                wr_s    = 1'b0;
                addr_s  = 4'd0;
                wdata_s = 32'd0;
            end
        endcase
    end

    // Sequencer state, datapath and master-side output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            idx_r           <= {IDX_W{1'b0}};
            pawn_r          <= {IDX_W{1'b0}};
            dest_r          <= 32'd0;
            total_r         <= 7'd0;
            count_r         <= 8'd0;
            clamp_r         <= 1'b0;
            gen_read_r      <= 1'b0;
            gen_write_r     <= 1'b0;
            gen_address_r   <= 4'd0;
            gen_writedata_r <= 32'd0;
        end else begin
            state_r         <= state_s;
            idx_r           <= idx_s;
            pawn_r          <= pawn_s;
            dest_r          <= dest_s;
            total_r         <= total_s;
            count_r         <= count_s;
            clamp_r         <= clamp_s;
            gen_read_r      <= rd_s;
            gen_write_r     <= wr_s;
            gen_address_r   <= addr_s;
            gen_writedata_r <= wdata_s;
        end
    end

    // CPU configuration registers; writes are accepted only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_r  <= 32'd0;
            base_r   <= 32'd0;
            colour_r <= 1'b0;
            mask_r   <= {NUM_PAWNS{1'b0}};
        end else if (slave_write && (state_r == IDLE)) begin
            case (slave_address)
                4'd1:    board_r  <= slave_writedata;
                4'd2:    base_r   <= slave_writedata;
                4'd3:    colour_r <= slave_writedata[0];
                4'd4:    mask_r   <= slave_writedata[NUM_PAWNS-1:0];
                default: board_r  <= board_r;
            endcase
        end else begin
            board_r <= board_r;
        end
    end

`ifdef PAWN_SCHED_PERF_EN
    logic [31:0] perf_r;

    // Cycle counter: cleared on start, counts active cycles, holds from DONE on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 32'd0;
        end else if (start_s) begin
            perf_r <= 32'd0;
        end else if ((state_r != IDLE) && (state_r != DONE)) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_rd_s = perf_r;
`else
    assign perf_rd_s = 32'd0;
`endif

    // A total read stalls the CPU until the sequence has finished accumulating.
    always_comb begin
        slave_waitrequest = 1'b0;
        if (slave_read && (slave_address == 4'd0) &&
            (state_r != IDLE) && (state_r != DONE)) begin
            slave_waitrequest = 1'b1;
        end else begin
            slave_waitrequest = 1'b0;
        end
    end

    // CPU read-data mux, driven to zero whenever no read is in progress.
    always_comb begin
        slave_readdata = 32'd0;
        if (slave_read) begin
            case (slave_address)
                4'd0:    slave_readdata = {25'd0, total_r};
                4'd1:    slave_readdata = board_r;
                4'd2:    slave_readdata = base_r;
                4'd3:    slave_readdata = {31'd0, colour_r};
                4'd4:    slave_readdata = 32'(mask_r);
                4'd5:    slave_readdata = {30'd0, clamp_r, (state_r != IDLE)};
                4'd6:    slave_readdata = perf_rd_s;
                default: slave_readdata = 32'd0;
            endcase
        end else begin
            slave_readdata = 32'd0;
        end
    end

endmodule

// File: doc/pawn_sched.md
Name: pawn_sched

Overview:
- Sequences the pawn move-generation accelerator across all pawns of one colour for a single CPU request.
- CPU-facing side: Avalon-MM slave. Pawn-facing side: Avalon-MM master driving the pawn block's slave port.
- For each selected pawn it programs the source board, piece ID and destination pointer, starts generation, and collects the board count.
- Destination boards are packed contiguously, 64 bytes each. The grand total is returned to the CPU.

Parameters:
- MAX_MOVES, 12: maximum boards one pawn may produce; larger reported counts are clamped and flagged.
- NUM_PAWNS, 8: pawn IDs iterated (magnitude 1..NUM_PAWNS).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- slave_waitrequest  output  1  CPU-side stall
- slave_address  input  4  CPU register select
- slave_read  input  1  CPU read strobe
- slave_readdata  output  32  CPU read data
- slave_write  input  1  CPU write strobe
- slave_writedata  input  32  CPU write data
- gen_waitrequest  input  1  pawn-block stall
- gen_address  output  4  pawn-block register select
- gen_read  output  1  pawn-block read strobe
- gen_readdata  input  32  pawn-block read data (board count)
- gen_write  output  1  pawn-block write strobe
- gen_writedata  output  32  pawn-block write data

Behaviour:
CPU register map (word addresses):
- 0: write = start (data ignored). Read = total boards; blocks until done.
- 1: source board address.
- 2: destination base address.
- 3: colour; bit0 = 0 white, 1 black.
- 4: pawn mask; bit i selects pawn i.
- 5: status, non-blocking. bit0 busy, bit1 clamp error (sticky until next start).

Slave side:
- Writes to 1–4 and start while idle complete with waitrequest low in the same cycle.
- Writes while busy complete immediately and are discarded; a start while busy is ignored.
- Read of 0 while busy holds waitrequest high until DONE, then returns the total.

Pawn-block register map (master targets):
- 1 source board, 2 piece ID, 3 destination, 0 start.
- Read of 0 stalls until finished, then returns the count.

Master handshake:
- Strobe, address and data are held stable until a rising edge samples gen_waitrequest = 0; that edge completes the transfer.
- Never more than one strobe asserted at a time.

FSM:
- IDLE -> (start) SCAN.
- SCAN:
  - find lowest i >= idx with mask[i] set; if none -> DONE;
  - else -> W_BOARD -> W_PIECE -> W_DEST -> W_START -> R_COUNT -> ACCUM -> SCAN with idx = i+1.
- DONE -> IDLE after one cycle.

Datapath:
- Piece ID = i+1 for white, -(i+1) as 32-bit two's complement for black.
- Destination pointer starts at the base register and advances by count*64 after each pawn.
- Count uses gen_readdata[7:0]; values > MAX_MOVES are clamped to MAX_MOVES and the clamp-error bit is set.
- Total is 7-bit, zero-extended to 32; max 96.

Edge cases:
- Mask = 0: IDLE -> SCAN -> DONE; total 0; no master traffic.
- Count 0: pointer unchanged.

Reset:
- Returns the FSM to IDLE and clears all registers, index, total and error.
- gen_read = gen_write = 0, gen_address = 0, gen_writedata = 0.
- slave_waitrequest = 0, slave_readdata = 0.
- Reset mid-sequence drops master strobes immediately; no completion is reported.

Optional Feature:
- Macro PAWN_SCHED_PERF_EN.
- Defined: a 32-bit cycle counter clears on start, increments every non-IDLE cycle, and freezes at DONE; it is readable at address 6.
- Undefined: the counter is absent and address 6 reads 0.

Test Plan:
- White, mask 8'h04, board 0x1000, dest 0x2000, model returns 2: master writes 1<-0x1000, 2<-3, 3<-0x2000, 0<-start, then reads 0; CPU read of 0 returns 2.
- Black, mask 8'h81, counts 3 then 1: piece IDs 32'hFFFFFFFF then 32'hFFFFFFF8; destinations base then base+192; total 4.
- Mask 0: start then read 0 returns 0 within 4 cycles; gen_read and gen_write never assert.
- Model holds gen_waitrequest high for 5 cycles on each transfer: address, data and strobe are stable throughout; final total is unchanged versus the zero-wait case.
- Model returns count 20 for one pawn: total counts 12, status reads 2'b11 while busy and 2'b10 after done; the next start clears bit1.
- Assert rst_n low during R_COUNT: all outputs reach reset values without waiting for a clock; a following start with mask 8'h01 runs normally and reports its count.
